merlin_mem_arb: RTL and testbench

Two-port to one-port memory arbiter placed directly downstream of the merlin32i core. It merges the core's instruction port (ireq/irsp) and data port (dreq/drsp) onto a single memory request/response channel. Arbitration is round-robin with a grant lock. An in-order tag FIFO routes each memory response back to the originating port. Memory responses are strictly in request order; the arbiter never reorders.

---
 rtl/merlin_mem_arb_pkg.sv | 10 +
 rtl/merlin_order_fifo.sv | 35 +++
 rtl/merlin_mem_arb.sv | 93 +++++++++
 tb/tb_merlin_mem_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/merlin_mem_arb_pkg.sv
// merlin_mem_arb_pkg: shared source IDs and order-tag layout for the memory arbiter
package merlin_mem_arb_pkg;
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;
  localparam int TAG_W = 2;
  typedef struct packed {
    logic src;
    logic wr;
  } tag_t;
endpackage

// File: rtl/merlin_order_fifo.sv
// merlin_order_fifo: in-order tag FIFO tracking the source of each outstanding memory request
module merlin_order_fifo
  import merlin_mem_arb_pkg::*;
#(
  parameter int DEPTH_X = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [TAG_W-1:0] mem [2**DEPTH_X];
  logic [DEPTH_X-1:0] wp, rp;
  logic [DEPTH_X:0] cnt;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= push ? wp + DEPTH_X'(1) : wp;
      rp <= pop ? rp + DEPTH_X'(1) : rp;
      cnt <= cnt + (DEPTH_X+1)'(push) - (DEPTH_X+1)'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = cnt[DEPTH_X];
  assign empty = cnt == '0;
endmodule

// File: rtl/merlin_mem_arb.sv
// merlin_mem_arb: round-robin merge of core I/D ports onto one in-order memory channel
module merlin_mem_arb
  import merlin_mem_arb_pkg::*;
#(
  parameter int C_ORDER_DEPTH_X = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  output logic        ireqready_o,
  input  logic        ireqvalid_i,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  input  logic        irspready_i,
  output logic        irspvalid_o,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqsize_i,
  input  logic        dreqdvalid_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o,
  input  logic        mreqready_i,
  output logic        mreqvalid_o,
  output logic        mreqwr_o,
  output logic [1:0]  mreqsize_o,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  output logic [31:0] mreqdata_o,
  output logic        mrspready_o,
  input  logic        mrspvalid_i,
  input  logic        mrsperr_i,
  input  logic [31:0] mrspdata_i
);
  logic last_grant, locked, lock_src, sel, act, full, empty, push, pop, dst_ready, rsp_ok;
  tag_t head;
  assign act = !reset_i;
  // A stalled request pins the grant so the memory sees a stable source and payload
  assign sel = locked ? lock_src :
               (ireqvalid_i && dreqvalid_i) ? ~last_grant : dreqvalid_i;
  always_comb begin
    mreqvalid_o = act & !full & (sel ? dreqvalid_i : ireqvalid_i);
    ireqready_o = act & (sel == SRC_I) & mreqready_i & !full & clk_en_i;
    dreqready_o = act & (sel == SRC_D) & mreqready_i & !full & clk_en_i;
    mreqwr_o = act & sel & dreqdvalid_i;
    mreqsize_o = !act ? 2'b00 : sel ? dreqsize_i : 2'b10;
    mreqhpl_o = !act ? 2'b00 : sel ? dreqhpl_i : ireqhpl_i;
    mreqaddr_o = !act ? 32'd0 : sel ? dreqaddr_i : ireqaddr_i;
    mreqdata_o = (act && sel) ? dreqdata_i : 32'd0;
  end
  assign push = mreqvalid_o & mreqready_i & clk_en_i;
  assign rsp_ok = act & !empty;
  assign dst_ready = head.src ? drspready_i : irspready_i;
  always_comb begin
    mrspready_o = rsp_ok & dst_ready & clk_en_i;
    irspvalid_o = rsp_ok & mrspvalid_i & (head.src == SRC_I);
    drspvalid_o = rsp_ok & mrspvalid_i & (head.src == SRC_D);
    irsprerr_o = act & mrsperr_i;
    drsprerr_o = act & mrsperr_i & !head.wr;
    drspwerr_o = act & mrsperr_i & head.wr;
    irspdata_o = act ? mrspdata_i : 32'd0;
    drspdata_o = act ? mrspdata_i : 32'd0;
  end
  assign pop = mrspready_o & mrspvalid_i;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant <= SRC_D;
      locked <= 1'b0;
      lock_src <= SRC_I;
    end else if (clk_en_i) begin
      last_grant <= push ? sel : last_grant;
      locked <= mreqvalid_o & !mreqready_i;
      lock_src <= sel;
    end
  end
  merlin_order_fifo #(.DEPTH_X(C_ORDER_DEPTH_X)) u_fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .push(push),
    .pop(pop),
    .din({sel, mreqwr_o}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_merlin_mem_arb.sv
// tb_merlin_mem_arb: directed checks of arbitration, grant lock, ordering, full/empty, clock enable and reset
module tb_merlin_mem_arb;
  logic clk_i = 1'b0, reset_i, clk_en_i;
  logic ireqready_o, ireqvalid_i, irspready_i, irspvalid_o, irsprerr_o;
  logic [1:0] ireqhpl_i;
  logic [31:0] ireqaddr_i, irspdata_o;
  logic dreqready_o, dreqvalid_i, dreqdvalid_i, drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
  logic [1:0] dreqsize_i, dreqhpl_i;
  logic [31:0] dreqaddr_i, dreqdata_i, drspdata_o;
  logic mreqready_i, mreqvalid_o, mreqwr_o, mrspready_o, mrspvalid_i, mrsperr_i;
  logic [1:0] mreqsize_o, mreqhpl_o;
  logic [31:0] mreqaddr_o, mreqdata_o, mrspdata_i;
  int n_chk = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  merlin_mem_arb #(.C_ORDER_DEPTH_X(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i), .ireqaddr_i(ireqaddr_i),
    .irspready_i(irspready_i), .irspvalid_o(irspvalid_o), .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i), .dreqdvalid_i(dreqdvalid_i),
    .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i), .dreqdata_i(dreqdata_i),
    .drspready_i(drspready_i), .drspvalid_o(drspvalid_o), .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o),
    .drspdata_o(drspdata_o),
    .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqwr_o(mreqwr_o), .mreqsize_o(mreqsize_o),
    .mreqhpl_o(mreqhpl_o), .mreqaddr_o(mreqaddr_o), .mreqdata_o(mreqdata_o),
    .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i), .mrsperr_i(mrsperr_i), .mrspdata_i(mrspdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ireqvalid_i = 0; ireqhpl_i = 0; ireqaddr_i = 0; irspready_i = 0;
    dreqvalid_i = 0; dreqsize_i = 0; dreqdvalid_i = 0; dreqhpl_i = 0; dreqaddr_i = 0; dreqdata_i = 0;
    drspready_i = 0; mreqready_i = 0; mrspvalid_i = 0; mrsperr_i = 0; mrspdata_i = 0;
  endtask

  initial begin
    idle();
    clk_en_i = 1;
    reset_i = 1;
    ireqvalid_i = 1; ireqaddr_i = 32'h100; mreqready_i = 1; mrspvalid_i = 1; irspready_i = 1;
    #2;
    chk("rst_mreqvalid", mreqvalid_o, 0);
    chk("rst_ireqready", ireqready_o, 0);
    chk("rst_mrspready", mrspready_o, 0);
    chk("rst_irspvalid", irspvalid_o, 0);
    chk("rst_mreqaddr", mreqaddr_o, 0);
    idle();
    #1 reset_i = 0;
    tick();
    // single instruction read
    ireqvalid_i = 1; ireqaddr_i = 32'h100; mreqready_i = 1;
    #1;
    chk("i_mreqvalid", mreqvalid_o, 1);
    chk("i_mreqaddr", mreqaddr_o, 32'h100);
    chk("i_mreqsize", mreqsize_o, 2);
    chk("i_mreqwr", mreqwr_o, 0);
    chk("i_ireqready", ireqready_o, 1);
    chk("i_dreqready", dreqready_o, 0);
    tick();
    idle();
    mrspvalid_i = 1; mrspdata_i = 32'hDEADBEEF; irspready_i = 1;
    #1;
    chk("i_irspvalid", irspvalid_o, 1);
    chk("i_irspdata", irspdata_o, 32'hDEADBEEF);
    chk("i_drspvalid", drspvalid_o, 0);
    chk("i_mrspready", mrspready_o, 1);
    tick();
    idle();
    // tie after reset: I first, then the D write
    reset_i = 1; #1 reset_i = 0;
    ireqvalid_i = 1; ireqaddr_i = 32'h200;
    dreqvalid_i = 1; dreqdvalid_i = 1; dreqaddr_i = 32'h300; dreqdata_i = 32'h55; dreqsize_i = 2'b00;
    mreqready_i = 1;
    #1;
    chk("tie_addr_i", mreqaddr_o, 32'h200);
    chk("tie_ireqready", ireqready_o, 1);
    chk("tie_dreqready", dreqready_o, 0);
    tick();
    ireqvalid_i = 0;
    #1;
    chk("tie_addr_d", mreqaddr_o, 32'h300);
    chk("tie_wr_d", mreqwr_o, 1);
    chk("tie_data_d", mreqdata_o, 32'h55);
    chk("tie_size_d", mreqsize_o, 0);
    chk("tie_dreqready", dreqready_o, 1);
    tick();
    idle();
    mrspvalid_i = 1; irspready_i = 1; drspready_i = 1;
    #1;
    chk("r1_irspvalid", irspvalid_o, 1);
    chk("r1_irsprerr", irsprerr_o, 0);
    chk("r1_drspvalid", drspvalid_o, 0);
    tick();
    mrsperr_i = 1;
    #1;
    chk("r2_drspvalid", drspvalid_o, 1);
    chk("r2_drspwerr", drspwerr_o, 1);
    chk("r2_drsprerr", drsprerr_o, 0);
    chk("r2_irspvalid", irspvalid_o, 0);
    tick();
    mrsperr_i = 0;
    #1;
    chk("empty_mrspready", mrspready_o, 0);
    chk("empty_irspvalid", irspvalid_o, 0);
    chk("empty_drspvalid", drspvalid_o, 0);
    idle();
    // make I the last grant so that an unlocked tie would pick D
    ireqvalid_i = 1; ireqaddr_i = 32'h10; mreqready_i = 1;
    tick();
    ireqaddr_i = 32'h400; mreqready_i = 0;
    #1;
    chk("lk_mreqvalid", mreqvalid_o, 1);
    chk("lk_addr0", mreqaddr_o, 32'h400);
    tick();
    dreqvalid_i = 1; dreqaddr_i = 32'h500;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lk_addr", mreqaddr_o, 32'h400);
      chk("lk_dreqready", dreqready_o, 0);
      tick();
    end
    mreqready_i = 1;
    #1;
    chk("lk_rel_ireqready", ireqready_o, 1);
    chk("lk_rel_addr", mreqaddr_o, 32'h400);
    tick();
    ireqvalid_i = 0;
    #1;
    chk("lk_d_addr", mreqaddr_o, 32'h500);
    chk("lk_d_dreqready", dreqready_o, 1);
    tick();
    dreqvalid_i = 0;
    // outstanding: I10, I400, D500; fourth fills the FIFO
    ireqvalid_i = 1; ireqaddr_i = 32'h600;
    tick();
    ireqaddr_i = 32'h700;
    #1;
    chk("full_mreqvalid", mreqvalid_o, 0);
    chk("full_ireqready", ireqready_o, 0);
    chk("full_dreqready", dreqready_o, 0);
    mrspvalid_i = 1; irspready_i = 1;
    #1;
    chk("full_pop_mrspready", mrspready_o, 1);
    chk("full_pop_mreqvalid", mreqvalid_o, 0);
    tick();
    mrspvalid_i = 0;
    #1;
    chk("freed_mreqvalid", mreqvalid_o, 1);
    chk("freed_ireqready", ireqready_o, 1);
    chk("freed_addr", mreqaddr_o, 32'h700);
    tick();
    ireqvalid_i = 0;
    // queue: I400, D500, I600, I700
    mrspvalid_i = 1; irspready_i = 1;
    tick();
    irspready_i = 0; drspready_i = 1; clk_en_i = 0;
    ireqvalid_i = 1; ireqaddr_i = 32'h800; mreqready_i = 1;
    #1;
    chk("ce_mrspready", mrspready_o, 0);
    chk("ce_drspvalid", drspvalid_o, 1);
    chk("ce_ireqready", ireqready_o, 0);
    chk("ce_mreqvalid", mreqvalid_o, 1);
    tick();
    tick();
    clk_en_i = 1;
    #1;
    chk("ce_resume_drspvalid", drspvalid_o, 1);
    chk("ce_resume_mrspready", mrspready_o, 1);
    chk("ce_resume_ireqready", ireqready_o, 1);
    tick();
    ireqvalid_i = 0; drspready_i = 0; irspready_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_irspvalid", irspvalid_o, 1);
      chk("drain_drspvalid", drspvalid_o, 0);
      tick();
    end
    #1;
    chk("drain_empty", mrspready_o, 0);
    idle();
    // asynchronous reset in the middle of a burst
    ireqvalid_i = 1; ireqaddr_i = 32'h900; mreqready_i = 1;
    tick();
    ireqaddr_i = 32'hA00;
    tick();
    mrspvalid_i = 1; irspready_i = 1; ireqaddr_i = 32'hB00;
    #1;
    chk("pre_rst_irspvalid", irspvalid_o, 1);
    #1 reset_i = 1;
    #1;
    chk("mid_rst_mreqvalid", mreqvalid_o, 0);
    chk("mid_rst_ireqready", ireqready_o, 0);
    chk("mid_rst_mrspready", mrspready_o, 0);
    chk("mid_rst_irspvalid", irspvalid_o, 0);
    chk("mid_rst_mreqaddr", mreqaddr_o, 0);
    ireqvalid_i = 0;
    #1 reset_i = 0;
    #1;
    chk("post_rst_mrspready", mrspready_o, 0);
    chk("post_rst_irspvalid", irspvalid_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
